// File: rtl/regfile_mp.sv
// Parametrised byte-writable register file: two registered read ports, one write port,
// optional hard-wired zero entry, write-to-read bypass and a sequenced bulk-clear sweep.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                rd_en1,
    input  logic [ADDR_W-1:0]   rd_addr1,
    output logic [DATA_W-1:0]   rd_data1,
    input  logic                rd_en2,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    localparam int                BYTES   = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    // state | meaning
    // IDLE  | normal read/write service
    // CLEAR | sweep zeroing entry[ptr] each enabled cycle; reads return 0, writes dropped
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_hit;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_V) && !(ZERO_R0 && (a == '0));
    endfunction

    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < BYTES; k++) begin
            wr_mask[8*k +: 8] = {8{wr_be[k]}};
        end
    end

    always_comb begin
        wr_old = '0;
        if (addr_ok(wr_addr)) begin
            wr_old = mem[wr_addr];
        end
    end

    assign wr_merged = (wr_old & ~wr_mask) | (wr_data & wr_mask);
    assign wr_hit    = (state == IDLE) && ce && wr_en && addr_ok(wr_addr);

    // Each port resolves its own bypass so both may hit the write address together.
    always_comb begin
        rd_next1 = '0;
        if (ce && rd_en1 && (state == IDLE) && addr_ok(rd_addr1)) begin
            if (BYPASS && wr_hit && (rd_addr1 == wr_addr)) begin
                rd_next1 = wr_merged;
            end else begin
                rd_next1 = mem[rd_addr1];
            end
        end
    end

    always_comb begin
        rd_next2 = '0;
        if (ce && rd_en2 && (state == IDLE) && addr_ok(rd_addr2)) begin
            if (BYPASS && wr_hit && (rd_addr2 == wr_addr)) begin
                rd_next2 = wr_merged;
            end else begin
                rd_next2 = mem[rd_addr2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            clr_done <= 1'b0;
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
            case (state)
                IDLE: begin
                    // A write on the request edge lands first; the sweep zeroes it later.
                    if (wr_hit) begin
                        mem[wr_addr] <= wr_merged;
                    end
                    if (ce && clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ce) begin
                        mem[ptr] <= '0;
                        if (ptr == LAST) begin
                            state    <= IDLE;
                            ptr      <= '0;
                            busy     <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are
// compared every cycle against a per-configuration behavioural model.
`timescale 1ns/1ps
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        rd_en1;
    logic [4:0]  rd_addr1;
    logic        rd_en2;
    logic [4:0]  rd_addr2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        clr_req;

    logic [31:0] rd1_o  [3];
    logic [31:0] rd2_o  [3];
    logic        busy_o [3];
    logic        done_o [3];

    int checks = 0;
    int errors = 0;

    // n=0: default, n=1: no bypass, n=2: depth 20 without zero entry
    int cfg_depth [3] = '{32, 32, 20};
    bit cfg_z     [3] = '{1'b1, 1'b1, 1'b0};
    bit cfg_b     [3] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] m_mem  [3][32];
    bit          m_busy [3];
    bit          m_done [3];
    int          m_ptr  [3];
    logic [31:0] m_rd1  [3];
    logic [31:0] m_rd2  [3];

    regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(1'b1), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_o[0]),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_req(clr_req), .busy(busy_o[0]), .clr_done(done_o[0]));

    regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_o[1]),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_req(clr_req), .busy(busy_o[1]), .clr_done(done_o[1]));

    regfile_mp #(.DATA_W(32), .DEPTH(20), .ADDR_W(5), .ZERO_R0(1'b0), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd1_o[2]),
        .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd2_o[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_req(clr_req), .busy(busy_o[2]), .clr_done(done_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit valid(input int n, input logic [4:0] a);
        return (int'(a) < cfg_depth[n]) && !(cfg_z[n] && a == 5'd0);
    endfunction

    function automatic logic [31:0] ref_read(input int n, input logic en, input logic [4:0] a,
                                             input bit wok, input logic [31:0] merged);
        if (!(ce && en && !m_busy[n])) return 32'h0;
        if (!valid(n, a)) return 32'h0;
        if (cfg_b[n] && wok && a == wr_addr) return merged;
        return m_mem[n][a];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 32; i++) m_mem[n][i] = 32'h0;
            m_busy[n] = 1'b0;
            m_done[n] = 1'b0;
            m_ptr[n]  = 0;
            m_rd1[n]  = 32'h0;
            m_rd2[n]  = 32'h0;
        end
    endtask

    task automatic model_step();
        for (int n = 0; n < 3; n++) begin
            logic [31:0] mask;
            logic [31:0] merged;
            bit          wok;
            mask = 32'h0;
            for (int k = 0; k < 4; k++) if (wr_be[k]) mask = mask | (32'hFF << (8 * k));
            wok    = !m_busy[n] && ce && wr_en && valid(n, wr_addr);
            merged = (m_mem[n][wr_addr] & ~mask) | (wr_data & mask);
            m_rd1[n]  = ref_read(n, rd_en1, rd_addr1, wok, merged);
            m_rd2[n]  = ref_read(n, rd_en2, rd_addr2, wok, merged);
            m_done[n] = 1'b0;
            if (m_busy[n]) begin
                if (ce) begin
                    m_mem[n][m_ptr[n]] = 32'h0;
                    if (m_ptr[n] == cfg_depth[n] - 1) begin
                        m_busy[n] = 1'b0;
                        m_done[n] = 1'b1;
                        m_ptr[n]  = 0;
                    end else begin
                        m_ptr[n]++;
                    end
                end
            end else begin
                if (wok) m_mem[n][wr_addr] = merged;
                if (ce && clr_req) begin
                    m_busy[n] = 1'b1;
                    m_ptr[n]  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int n = 0; n < 3; n++) begin
            check($sformatf("rd_data1[u%0d]", n), rd1_o[n], m_rd1[n]);
            check($sformatf("rd_data2[u%0d]", n), rd2_o[n], m_rd2[n]);
            check($sformatf("busy[u%0d]", n), {31'h0, busy_o[n]}, {31'h0, m_busy[n]});
            check($sformatf("clr_done[u%0d]", n), {31'h0, done_o[n]}, {31'h0, m_done[n]});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_in();
        ce = 1'b1; rd_en1 = 1'b0; rd_addr1 = 5'd0; rd_en2 = 1'b0; rd_addr2 = 5'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; wr_be = 4'h0; clr_req = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        idle_in();
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle_in();
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        idle_in();
        rd_en1 = 1'b1; rd_addr1 = a1; rd_en2 = 1'b1; rd_addr2 = a2;
        tick();
        idle_in();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        #4;
        rst_n = 1'b1;
    endtask

    int busy_cnt [3];
    int done_cnt [3];

    initial begin
        rst_n = 1'b1;
        idle_in();
        #1 rst_n = 1'b0;
        #7;
        model_reset();
        check_outputs();
        rst_n = 1'b1;

        // reset with preloaded entries, then read 5 and 31
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom, 4'hF);
        apply_reset();
        do_read(5'd5, 5'd31);
        check("reset_rd1_addr5", rd1_o[0], 32'h0);
        check("reset_rd2_addr31", rd2_o[0], 32'h0);

        // byte-enable merge
        do_write(5'd3, 32'hAABBCCDD, 4'hF);
        do_write(5'd3, 32'h11223344, 4'b0101);
        do_read(5'd3, 5'd3);
        check("byte_merge", rd1_o[0], 32'hAA22CC44);

        // same-edge write and read of address 7 on both ports
        idle_in();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; wr_be = 4'hF;
        rd_en1 = 1'b1; rd_addr1 = 5'd7; rd_en2 = 1'b1; rd_addr2 = 5'd7;
        tick();
        idle_in();
        check("bypass_on_p1", rd1_o[0], 32'h12345678);
        check("bypass_on_p2", rd2_o[0], 32'h12345678);
        check("bypass_off_p1", rd1_o[1], 32'h0);
        check("bypass_off_p2", rd2_o[1], 32'h0);
        do_read(5'd7, 5'd7);
        check("bypass_off_later", rd1_o[1], 32'h12345678);

        // zero entry and out-of-range address
        do_write(5'd0, 32'hFFFFFFFF, 4'hF);
        do_read(5'd0, 5'd0);
        check("zero_entry", rd1_o[0], 32'h0);
        check("no_zero_entry", rd1_o[2], 32'hFFFFFFFF);
        do_write(5'd25, 32'hDEADBEEF, 4'hF);
        do_read(5'd25, 5'd25);
        check("out_of_range", rd1_o[2], 32'h0);

        // randomized traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            ce       = ($urandom_range(0, 7) != 0);
            rd_en1   = $urandom_range(0, 1);
            rd_addr1 = 5'($urandom_range(0, 31));
            rd_en2   = $urandom_range(0, 1);
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            wr_en    = $urandom_range(0, 1);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            clr_req  = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle_in();
        for (int c = 0; c < 40; c++) tick();

        // bulk clear with a same-edge write, two ce-low cycles and a write while busy
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i), 4'hF);
        for (int n = 0; n < 3; n++) begin busy_cnt[n] = 0; done_cnt[n] = 0; end
        idle_in();
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000ABCD; wr_be = 4'hF;
        tick();
        for (int n = 0; n < 3; n++) begin
            busy_cnt[n] += busy_o[n];
            done_cnt[n] += done_o[n];
        end
        for (int k = 1; k <= 40; k++) begin
            idle_in();
            ce = !(k == 10 || k == 11);
            rd_en1 = 1'b1; rd_addr1 = 5'(k % 32);
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
            end
            if (k == 20) clr_req = 1'b1;
            tick();
            for (int n = 0; n < 3; n++) begin
                busy_cnt[n] += busy_o[n];
                done_cnt[n] += done_o[n];
            end
        end
        idle_in();
        check("busy_cycles_u0", 32'(busy_cnt[0]), 32'd34);
        check("busy_cycles_u1", 32'(busy_cnt[1]), 32'd34);
        check("busy_cycles_u2", 32'(busy_cnt[2]), 32'd22);
        check("done_pulses_u0", 32'(done_cnt[0]), 32'd1);
        check("done_pulses_u2", 32'(done_cnt[2]), 32'd1);
        for (int a = 0; a < 32; a++) begin
            do_read(5'(a), 5'(31 - a));
            check($sformatf("cleared_entry_%0d", a), rd1_o[0], 32'h0);
        end

        // reset while the sweep pointer is at 10
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom | 32'h1, 4'hF);
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        for (int k = 0; k < 10; k++) tick();
        apply_reset();
        check("midsweep_busy", {31'h0, busy_o[0]}, 32'h0);
        check("midsweep_done", {31'h0, done_o[0]}, 32'h0);
        for (int a = 0; a < 32; a++) do_read(5'(a), 5'(a));
        idle_in();
        clr_req = 1'b1;
        tick();
        check("reclear_accepted", {31'h0, busy_o[0]}, 32'h1);
        idle_in();
        for (int k = 0; k < 40; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
